// File: rtl/lm07_pkg.sv
// Shared constants and state encoding for the LM07 serial-interface responder.
package lm07_pkg;
    localparam int TEMP_W = 13;
    localparam int FRAME_BITS = 16;
    localparam logic [2:0] PAD_BITS = 3'b111;
    localparam int FRAME_W = TEMP_W + 3;
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;
endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an idle-high asynchronous pin, with rise/fall pulses.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q[0] <= pin_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & hist_q;
endmodule

// File: rtl/lm07_sio_responder.sv
// LM07-style 3-wire responder: shifts {temperature, 3'b111} MSB-first to the host.
//
// state | meaning
// IDLE  | deselected, waiting for chip-select to fall
// SHIFT | driving SIO, advancing one bit per serial-clock fall
// DONE  | all bits sent, SIO released, waiting for deselect
module lm07_sio_responder
    import lm07_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n_pin,
    input  logic              sck_pin,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic              temp_valid,
    output logic              sio_out,
    output logic              sio_oe,
    output logic              frame_done,
    output logic              busy
);
    state_e             state_q;
    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [TEMP_W-1:0]  shadow_q;
    logic [TEMP_W-1:0]  pending_q;
    logic               pend_vld_q;
    logic               sio_oe_q;
    logic               frame_done_q;
    logic               busy_q;

    logic cs_level, cs_rise, cs_fall;
    logic sck_level_unused, sck_rise_unused, sck_fall;
    logic start, end_frame;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (cs_n_pin),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .pin_i   (sck_pin),
        .level_o (sck_level_unused),
        .rise_o  (sck_rise_unused),
        .fall_o  (sck_fall)
    );

    assign start     = (state_q == IDLE) & cs_fall & ~cs_rise;
    assign end_frame = cs_rise & busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            sio_oe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            // Deselect always wins, including against a simultaneous clock fall.
            if (cs_rise) begin
                state_q  <= IDLE;
                sio_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            shift_q   <= {shadow_q, PAD_BITS};
                            bit_cnt_q <= '0;
                            sio_oe_q  <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sck_fall && !cs_level) begin
                            shift_q   <= {shift_q[FRAME_W-2:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                                sio_oe_q     <= 1'b0;
                                frame_done_q <= 1'b1;
                                state_q      <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Samples arriving mid-frame are parked and folded in as busy falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
        end else if (temp_valid) begin
            if (start || (busy_q && !end_frame)) begin
                pending_q  <= temp_in;
                pend_vld_q <= 1'b1;
            end else begin
                shadow_q   <= temp_in;
                pend_vld_q <= 1'b0;
            end
        end else if (end_frame && pend_vld_q) begin
            shadow_q   <= pending_q;
            pend_vld_q <= 1'b0;
        end
    end

    assign sio_out    = shift_q[FRAME_W-1];
    assign sio_oe     = sio_oe_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_lm07_sio_responder.sv
// Directed bench for the LM07 responder; a monitor rebuilds each frame from SIO and checks it against a queue.
module tb_lm07_sio_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n_pin;
    logic        sck_pin;
    logic [12:0] temp_in;
    logic        temp_valid;
    logic        sio_out;
    logic        sio_oe;
    logic        frame_done;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          fd_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rx = '0;
    int          rx_bits = 0;
    logic        sck_prev = 1'b1;
    logic        cs_prev = 1'b1;

    lm07_sio_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n_pin   (cs_n_pin),
        .sck_pin    (sck_pin),
        .temp_in    (temp_in),
        .temp_valid (temp_valid),
        .sio_out    (sio_out),
        .sio_oe     (sio_oe),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: host-side view of SIO, sampled as each SC fall reaches the pin.
    always @(negedge clk) begin
        logic [15:0] e;
        if (cs_prev && !cs_n_pin) begin
            rx = '0;
            rx_bits = 0;
        end
        if (sck_prev && !sck_pin && sio_oe) begin
            rx = {rx[14:0], sio_out};
            rx_bits++;
        end
        if (frame_done) begin
            fd_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected actual=%0h expected=none", rx);
            end else begin
                e = exp_q.pop_front();
                chk("frame_word", rx, e);
                chk("frame_bits", rx_bits, 16);
            end
        end
        sck_prev = sck_pin;
        cs_prev  = cs_n_pin;
    end

    task automatic load(input logic [12:0] v);
        @(posedge clk); #1 temp_in = v; temp_valid = 1'b1;
        @(posedge clk); #1 temp_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic cs_low();
        @(posedge clk); #1 cs_n_pin = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic cs_high();
        @(posedge clk); #1 cs_n_pin = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic sck_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 sck_pin = 1'b0;
            repeat (8) @(posedge clk);
            #1 sck_pin = 1'b1;
            repeat (8) @(posedge clk);
        end
    endtask

    task automatic full_frame(input logic [15:0] exp);
        exp_q.push_back(exp);
        cs_low();
        @(negedge clk);
        chk("frame_busy", busy, 1);
        chk("frame_oe", sio_oe, 1);
        sck_pulses(16);
        @(negedge clk);
        chk("end_oe_low", sio_oe, 0);
        cs_high();
        @(negedge clk);
        chk("end_busy_low", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; cs_n_pin = 1'b1; sck_pin = 1'b1;
        temp_valid = 1'b0; temp_in = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sio_out", sio_out, 0);
        chk("rst_sio_oe", sio_oe, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);

        // +25 C and -12.5 C
        load(13'h0190);
        full_frame(16'h0C87);
        chk("fd_count_a", fd_cnt, 1);
        load(13'h1F38);
        full_frame(16'hF9C7);
        chk("fd_count_b", fd_cnt, 2);

        // Sample arriving mid-frame must not disturb the frame in flight
        load(13'h0010);
        exp_q.push_back(16'h0087);
        cs_low();
        sck_pulses(5);
        load(13'h0020);
        sck_pulses(11);
        cs_high();
        full_frame(16'h0107);
        chk("fd_count_upd", fd_cnt, 4);

        // Abort after 7 bits
        load(13'h0ABC);
        cs_low();
        sck_pulses(7);
        @(negedge clk);
        chk("abort_pre_oe", sio_oe, 1);
        @(posedge clk); #1 cs_n_pin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_oe", sio_oe, 0);
        chk("abort_busy", busy, 0);
        sck_pulses(3);
        @(negedge clk);
        chk("idle_sck_oe", sio_oe, 0);
        chk("idle_sck_busy", busy, 0);
        chk("fd_count_abort", fd_cnt, 4);
        full_frame(16'h55E7);
        chk("fd_count_restart", fd_cnt, 5);

        // 20 clocks in one frame
        load(13'h0001);
        exp_q.push_back(16'h000F);
        cs_low();
        sck_pulses(16);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 sck_pin = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk);
            chk("extra_oe", sio_oe, 0);
            @(posedge clk); #1 sck_pin = 1'b1;
            repeat (8) @(posedge clk);
        end
        cs_high();
        chk("fd_count_extra", fd_cnt, 6);

        // Async reset at bit 9
        load(13'h0155);
        cs_low();
        sck_pulses(9);
        @(negedge clk);
        chk("pre_reset_oe", sio_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_oe_now", sio_oe, 0);
        chk("reset_busy_now", busy, 0);
        #1 cs_n_pin = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        sck_pulses(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_sio_out", sio_out, 0);
            chk("post_rst_oe", sio_oe, 0);
            chk("post_rst_fd", frame_done, 0);
            chk("post_rst_busy", busy, 0);
        end
        chk("fd_count_reset", fd_cnt, 6);
        full_frame(16'h0007);
        chk("fd_count_final", fd_cnt, 7);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
